// File: rtl/soc_reset_ctrl_if.sv
// Reset controller status/request bundle: clock-lock and software-reset inputs
// toward the controller, per-domain resets and status back out.
interface soc_reset_ctrl_if #(
    parameter int NDOMAINS = 4
);
    logic                ClkStable;
    logic                SwResetReq;
    logic [NDOMAINS-1:0] SwResetMask;
    logic [NDOMAINS-1:0] DomainRst;
    logic                ResetDone;
    logic                ResetCause;

    modport master (
        output ClkStable, SwResetReq, SwResetMask,
        input  DomainRst, ResetDone, ResetCause
    );

    modport slave (
        input  ClkStable, SwResetReq, SwResetMask,
        output DomainRst, ResetDone, ResetCause
    );
endinterface

// File: rtl/soc_reset_ctrl.sv
// SoC reset controller: synchronizes the external reset, waits for clock lock,
// then releases domains in index order; also handles masked software resets.
module soc_reset_ctrl #(
    parameter int NDOMAINS       = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int HOLD_CYCLES    = 16,
    parameter int STAGGER_CYCLES = 4
) (
    input logic clk,
    input logic reset,
    soc_reset_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(HOLD_CYCLES + NDOMAINS * STAGGER_CYCLES + 2);

    if (NDOMAINS < 1 || SYNC_STAGES < 2 || HOLD_CYCLES < 1 || STAGGER_CYCLES < 1) begin : g_bad_params
        $error("soc_reset_ctrl: illegal parameter value");
    end

    typedef enum logic [2:0] {
        SYNC, WAITCLK, HOLD, STAGGER, RUN, SWHOLD, SWSTAGGER
    } state_t;

    state_t               state, state_next;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]     cnt, cnt_next;
    logic [NDOMAINS-1:0]  dom_q, dom_next;
    logic                 done_q, done_next;
    logic                 cause_q, cause_next;
    logic                 sync_drop;

    // The chain output is 0 after the edge on which bit SYNC_STAGES-2 is
    // already 0, so the start edge coincides with the synchronized release.
    assign sync_drop = ~sync_q[SYNC_STAGES-2] | ~sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q  <= '1;
            state   <= SYNC;
            cnt     <= '0;
            dom_q   <= '1;
            done_q  <= 1'b0;
            cause_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], 1'b0};
            state   <= state_next;
            cnt     <= cnt_next;
            dom_q   <= dom_next;
            done_q  <= done_next;
            cause_q <= cause_next;
        end
    end

    always_comb begin
        state_next = state;
        dom_next   = dom_q;
        done_next  = done_q;
        cause_next = cause_q;
        cnt_next   = (&cnt) ? cnt : cnt + 1'b1;

        case (state)
            SYNC: begin
                if (sync_drop) begin
                    if (bus.ClkStable) begin
                        state_next = HOLD;
                        cnt_next   = '0;
                    end else begin
                        state_next = WAITCLK;
                    end
                end
            end
            WAITCLK: begin
                if (bus.ClkStable) begin
                    state_next = HOLD;
                    cnt_next   = '0;
                end
            end
            HOLD, STAGGER, SWHOLD, SWSTAGGER: begin
                // Every index owns its slot; clearing an unmasked bit is a no-op.
                for (int unsigned i = 0; i < NDOMAINS; i++) begin
                    if (cnt == CNT_W'(HOLD_CYCLES + i * STAGGER_CYCLES - 1))
                        dom_next[i] = 1'b0;
                end
                if (state == HOLD && cnt == CNT_W'(HOLD_CYCLES - 1))
                    state_next = STAGGER;
                if (state == SWHOLD && cnt == CNT_W'(HOLD_CYCLES - 1))
                    state_next = SWSTAGGER;
                if ((state == STAGGER || state == SWSTAGGER) &&
                    cnt == CNT_W'(HOLD_CYCLES + (NDOMAINS - 1) * STAGGER_CYCLES)) begin
                    state_next = RUN;
                    done_next  = 1'b1;
                end
            end
            RUN: begin
                if (bus.SwResetReq && (|bus.SwResetMask)) begin
                    dom_next   = bus.SwResetMask;
                    done_next  = 1'b0;
                    cause_next = 1'b1;
                    state_next = SWHOLD;
                    cnt_next   = '0;
                end
            end
            default: state_next = SYNC;
        endcase
    end

    assign bus.DomainRst  = dom_q;
    assign bus.ResetDone  = done_q;
    assign bus.ResetCause = cause_q;
endmodule
